// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Purpose:
//   Shared definitions for the parametrised pipeline stage chain.
//   - Default geometry constants that datapath variants start from.
//   - The per-stage control bundle (stall/flush) used by each stage register.
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Default depth and payload width of a classic decode/execute/memory/
  // writeback chain.
  localparam int PIPE_DEFAULT_STAGES = 4;
  localparam int PIPE_DEFAULT_WIDTH  = 32;

  // The retire counter feeds a 64-bit CSR, so it defaults to full width.
  localparam int RETIRE_CNT_WIDTH    = 64;

  // Control seen by a single stage. Flush has priority over stall.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   One pipeline stage register: a DATA_WIDTH payload plus a valid bit,
//   with its own stall (hold) and flush (kill) control.
//
// Ports:
//   clk_i      in   clock, rising-edge
//   reset_i    in   asynchronous active-low reset
//   upData_i   in   payload offered by the upstream stage
//   upValid_i  in   upstream valid, already masked by the upstream stall
//   ctrl_i     in   {stall, flush} for this stage
//   data_o     out  registered payload
//   valid_o    out  registered valid bit
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DEFAULT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] upData_i,
  input  logic                  upValid_i,
  input  stage_ctrl_t           ctrl_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_q;
  logic                  valid_d;

  // Next-state selection. Flush clears the payload as well as the valid
  // bit so a killed instruction leaves no stale data visible to debug
  // or trace logic. Stall simply holds. Otherwise the stage copies its
  // upstream neighbour; a stalled upstream arrives here already invalid,
  // which is what turns a stall mismatch into a bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (ctrl_i.flush) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!ctrl_i.stall) begin
      data_d  = upData_i;
      valid_d = upValid_i;
    end
  end

  // Stage state register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule : pipe_stage_reg

// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//
// Purpose:
//   Parametrised chain of NUM_STAGES pipe_stage_reg instances carrying a
//   DATA_WIDTH payload plus valid bit, with per-stage stall and flush.
//   Also provides a retire strobe, a wrapping retire counter and an
//   occupancy count (number of valid stages) for CSRs / perf counters.
//
// Ports:
//   clk_i           in   clock, rising-edge
//   reset_i         in   asynchronous active-low reset
//   in_data_i       in   payload entering stage 0
//   in_valid_i      in   in_data_i carries a real instruction
//   stall_i         in   per-stage hold, bit k freezes stage k
//   flush_i         in   per-stage kill, bit k invalidates stage k
//   stage_data_o    out  stage k payload at [k*DATA_WIDTH +: DATA_WIDTH]
//   stage_valid_o   out  per-stage valid bits
//   retire_o        out  an instruction leaves the last stage this cycle
//   retire_count_o  out  running (wrapping) count of retired instructions
//   occupancy_o     out  number of valid stages
//   protocol_err_o  out  sticky illegal stall-pattern flag
//
// Configuration:
//   PIPE_STAGE_CHAIN_PROTOCOL_CHECK_EN - when defined, builds a checker that
//   flags an upstream stage overwriting a held downstream stage. When
//   undefined, protocol_err_o is tied low and no checker exists.
// ---------------------------------------------------------------------------
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = PIPE_DEFAULT_STAGES,
  parameter int DATA_WIDTH = PIPE_DEFAULT_WIDTH,
  parameter int CNT_WIDTH  = RETIRE_CNT_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [DATA_WIDTH-1:0]            in_data_i,
  input  logic                             in_valid_i,
  input  logic [NUM_STAGES-1:0]            stall_i,
  input  logic [NUM_STAGES-1:0]            flush_i,
  output logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data_o,
  output logic [NUM_STAGES-1:0]            stage_valid_o,
  output logic                             retire_o,
  output logic [CNT_WIDTH-1:0]             retire_count_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy_o,
  output logic                             protocol_err_o
);

  localparam int OCC_WIDTH = $clog2(NUM_STAGES + 1);

  logic [DATA_WIDTH-1:0] stageData [NUM_STAGES];
  logic [NUM_STAGES-1:0] stageValid;

  // Stage chain. Stage 0 is fed from the input port with an implicit
  // upstream stall of 0; every later stage takes the previous stage's
  // payload and a valid that is cleared when that previous stage stalls,
  // so a stalled upstream feeding an advancing downstream yields a bubble.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : gStage
    logic [DATA_WIDTH-1:0] upData;
    logic                  upValid;
    stage_ctrl_t           ctrl;

    if (k == 0) begin : gHead
      assign upData  = in_data_i;
      assign upValid = in_valid_i;
    end else begin : gBody
      assign upData  = stageData[k-1];
      assign upValid = stageValid[k-1] & ~stall_i[k-1];
    end

    assign ctrl.stall = stall_i[k];
    assign ctrl.flush = flush_i[k];

    pipe_stage_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) uStage (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .upData_i  (upData),
      .upValid_i (upValid),
      .ctrl_i    (ctrl),
      .data_o    (stageData[k]),
      .valid_o   (stageValid[k])
    );

    assign stage_data_o[k*DATA_WIDTH +: DATA_WIDTH] = stageData[k];
  end

  assign stage_valid_o = stageValid;

  // An instruction retires when the last stage holds a valid entry that is
  // neither held back nor killed this cycle.
  assign retire_o = stageValid[NUM_STAGES-1]
                  & ~stall_i[NUM_STAGES-1]
                  & ~flush_i[NUM_STAGES-1];

  // Retire counter; wraps naturally at 2^CNT_WIDTH.
  logic [CNT_WIDTH-1:0] retireCount_q;
  logic [CNT_WIDTH-1:0] retireCount_d;

  always_comb begin
    retireCount_d = retireCount_q;
    if (retire_o) begin
      retireCount_d = retireCount_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      retireCount_q <= '0;
    end else begin
      retireCount_q <= retireCount_d;
    end
  end

  assign retire_count_o = retireCount_q;

  // Occupancy is a plain popcount of the valid bits.
  logic [OCC_WIDTH-1:0] occupancy;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occupancy = occupancy + OCC_WIDTH'(stageValid[k]);
    end
  end

  assign occupancy_o = occupancy;

`ifdef PIPE_STAGE_CHAIN_PROTOCOL_CHECK_EN
  // A hazard exists at stage k when it is held while its upstream neighbour
  // advances with a valid entry and the held stage is not being flushed:
  // the upstream instruction would be lost. The hazard unit is expected to
  // stall every stage upstream of a held stage.
  logic [NUM_STAGES-1:0] hazard;
  logic                  protErr_q;
  logic                  protErr_d;

  always_comb begin
    hazard = '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      hazard[k] = stall_i[k] & ~stall_i[k-1] & ~flush_i[k] & stageValid[k-1];
    end
  end

  // Sticky until reset.
  always_comb begin
    protErr_d = protErr_q | (|hazard);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      protErr_q <= 1'b0;
    end else begin
      protErr_q <= protErr_d;
    end
  end

  assign protocol_err_o = protErr_q;

  stallPatternLegal : assert property (
    @(posedge clk_i) disable iff (!reset_i) !(|hazard)
  ) else $warning("pipe_stage_chain: held stage overwritten by upstream (hazard=%b)", hazard);
`else
  assign protocol_err_o = 1'b0;
`endif

endmodule : pipe_stage_chain

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Purpose:
//   Directed testbench for pipe_stage_chain (N=4, W=32, CNT_WIDTH=4).
//   Each scenario task drives its own stimulus and compares against
//   hand-computed values. Inputs change 1 time unit after the rising edge
//   and outputs are observed at that same point.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;

  localparam int N = 4;
  localparam int W = 32;
  localparam int C = 4;

`ifdef PIPE_STAGE_CHAIN_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [W-1:0]   in_data_i;
  logic           in_valid_i;
  logic [N-1:0]   stall_i;
  logic [N-1:0]   flush_i;
  logic [N*W-1:0] stage_data_o;
  logic [N-1:0]   stage_valid_o;
  logic           retire_o;
  logic [C-1:0]   retire_count_o;
  logic [2:0]     occupancy_o;
  logic           protocol_err_o;

  int checks   = 0;
  int failures = 0;

  pipe_stage_chain #(
    .NUM_STAGES (N),
    .DATA_WIDTH (W),
    .CNT_WIDTH  (C)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .stage_data_o   (stage_data_o),
    .stage_valid_o  (stage_valid_o),
    .retire_o       (retire_o),
    .retire_count_o (retire_count_o),
    .occupancy_o    (occupancy_o),
    .protocol_err_o (protocol_err_o)
  );

  // Free-running clock, period 10.
  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] stageData(input int k);
    return stage_data_o[k*W +: W];
  endfunction

  // Drive all data-path inputs at once.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                               input logic [N-1:0] st, input logic [N-1:0] fl);
    in_valid_i = v;
    in_data_i  = d;
    stall_i    = st;
    flush_i    = fl;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reset values while reset is held low.
  task automatic test_reset();
    reset_i = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    #3;
    checks++;
    if (stage_valid_o !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b, expected %b", stage_valid_o, 4'b0000);
    end
    checks++;
    if (stage_data_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h, expected 0", stage_data_o);
    end
    checks++;
    if (retire_count_o !== 4'd0 || retire_o !== 1'b0 || occupancy_o !== 3'd0 || protocol_err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_misc: got cnt=%0d ret=%b occ=%0d err=%b, expected 0 0 0 0",
               retire_count_o, retire_o, occupancy_o, protocol_err_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    step();
  endtask

  // Three back-to-back instructions flow through and retire.
  task automatic test_flow_through();
    applyStimulus(1'b1, 32'h11, '0, '0); step();
    applyStimulus(1'b1, 32'h22, '0, '0); step();
    applyStimulus(1'b1, 32'h33, '0, '0); step();
    applyStimulus(1'b0, 32'h0,  '0, '0); step();
    checks++;
    if (stageData(3) !== 32'h11 || stage_valid_o[3] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flow_stage3: got %h/%b, expected 00000011/1", stageData(3), stage_valid_o[3]);
    end
    checks++;
    if (stageData(2) !== 32'h22 || stageData(1) !== 32'h33) begin
      failures++;
      $display("[TB] FAIL flow_order: got s2=%h s1=%h, expected 22 33", stageData(2), stageData(1));
    end
    checks++;
    if (occupancy_o !== 3'd3) begin
      failures++;
      $display("[TB] FAIL flow_occupancy: got %0d, expected 3", occupancy_o);
    end
    checks++;
    if (retire_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flow_retire1: got %b, expected 1", retire_o);
    end
    step();
    checks++;
    if (retire_o !== 1'b1 || stageData(3) !== 32'h22) begin
      failures++;
      $display("[TB] FAIL flow_retire2: got %b/%h, expected 1/00000022", retire_o, stageData(3));
    end
    step();
    checks++;
    if (retire_o !== 1'b1 || stageData(3) !== 32'h33) begin
      failures++;
      $display("[TB] FAIL flow_retire3: got %b/%h, expected 1/00000033", retire_o, stageData(3));
    end
    step();
    checks++;
    if (retire_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flow_retire_end: got %b, expected 0", retire_o);
    end
    checks++;
    if (retire_count_o !== 4'd3) begin
      failures++;
      $display("[TB] FAIL flow_count: got %0d, expected 3", retire_count_o);
    end
  endtask

  // Stalling stages 0/1 while 2/3 advance inserts bubbles.
  task automatic test_bubble();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + i, '0, '0);
      step();
    end
    checks++;
    if (occupancy_o !== 3'd4) begin
      failures++;
      $display("[TB] FAIL bubble_full: got %0d, expected 4", occupancy_o);
    end
    applyStimulus(1'b0, 32'h0, 4'b0011, '0);
    step();
    step();
    checks++;
    if (stageData(0) !== 32'hA3 || stageData(1) !== 32'hA2) begin
      failures++;
      $display("[TB] FAIL bubble_hold: got s0=%h s1=%h, expected a3 a2", stageData(0), stageData(1));
    end
    checks++;
    if (stage_valid_o !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL bubble_valid: got %b, expected 0011", stage_valid_o);
    end
    checks++;
    if (occupancy_o !== 3'd2) begin
      failures++;
      $display("[TB] FAIL bubble_occupancy: got %0d, expected 2", occupancy_o);
    end
    checks++;
    if (retire_count_o !== 4'd5) begin
      failures++;
      $display("[TB] FAIL bubble_count: got %0d, expected 5", retire_count_o);
    end
    applyStimulus(1'b0, 32'h0, '0, 4'b1111);
    step();
    checks++;
    if (stage_valid_o !== 4'b0000 || stage_data_o !== '0 || retire_count_o !== 4'd5) begin
      failures++;
      $display("[TB] FAIL flush_all: got v=%b d=%h cnt=%0d, expected 0000 0 5",
               stage_valid_o, stage_data_o, retire_count_o);
    end
  endtask

  // Flush beats stall on the same stage.
  task automatic test_flush_priority();
    applyStimulus(1'b1, 32'hAA, '0, '0); step();
    applyStimulus(1'b0, 32'h0,  '0, '0); step();
    checks++;
    if (stageData(1) !== 32'hAA || stage_valid_o !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL fp_setup: got %h/%b, expected 000000aa/0010", stageData(1), stage_valid_o);
    end
    applyStimulus(1'b0, 32'h0, 4'b0010, 4'b0010);
    step();
    checks++;
    if (stage_valid_o[1] !== 1'b0 || stageData(1) !== 32'h0) begin
      failures++;
      $display("[TB] FAIL fp_stage1: got %b/%h, expected 0/00000000", stage_valid_o[1], stageData(1));
    end
    checks++;
    if (stage_valid_o[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fp_stage2: got %b, expected 0", stage_valid_o[2]);
    end
    applyStimulus(1'b0, 32'h0, '0, '0);
    step();
    checks++;
    if (stage_valid_o !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL fp_drain: got %b, expected 0000", stage_valid_o);
    end
  endtask

  // 4-bit counter wraps 15 -> 0; flush of last stage suppresses retire.
  task automatic test_retire_wrap();
    #2 reset_i = 1'b0;
    #2 reset_i = 1'b1;
    checks++;
    if (retire_count_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL wrap_clear: got %0d, expected 0", retire_count_o);
    end
    step();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, 32'h100 + i, '0, '0);
      step();
    end
    checks++;
    if (retire_count_o !== 4'd15 || retire_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_preload: got %0d/%b, expected 15/1", retire_count_o, retire_o);
    end
    step();
    checks++;
    if (retire_count_o !== 4'd0) begin
      failures++;
      $display("[TB] FAIL wrap_zero: got %0d, expected 0", retire_count_o);
    end
    applyStimulus(1'b0, 32'h0, '0, 4'b1000);
    #1;
    checks++;
    if (retire_o !== 1'b0 || stage_valid_o[3] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_suppress: got ret=%b v3=%b, expected 0 1", retire_o, stage_valid_o[3]);
    end
    step();
    checks++;
    if (retire_count_o !== 4'd0 || stage_valid_o[3] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_count: got %0d/%b, expected 0/0", retire_count_o, stage_valid_o[3]);
    end
    applyStimulus(1'b0, 32'h0, '0, 4'b1111);
    step();
    applyStimulus(1'b0, 32'h0, '0, '0);
  endtask

  // Reset asserted between edges clears everything immediately.
  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hC0 + i, '0, '0);
      step();
    end
    checks++;
    if (occupancy_o !== 3'd4 || retire_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ar_full: got %0d/%b, expected 4/1", occupancy_o, retire_o);
    end
    #2 reset_i = 1'b0;
    #1;
    checks++;
    if (stage_valid_o !== 4'b0000 || stage_data_o !== '0 || retire_o !== 1'b0 ||
        retire_count_o !== 4'd0 || occupancy_o !== 3'd0) begin
      failures++;
      $display("[TB] FAIL ar_clear: got v=%b d=%h ret=%b cnt=%0d occ=%0d, expected all 0",
               stage_valid_o, stage_data_o, retire_o, retire_count_o, occupancy_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    applyStimulus(1'b1, 32'hCAFE, '0, '0);
    step();
    applyStimulus(1'b0, 32'h0, '0, '0);
    step();
    step();
    checks++;
    if (retire_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ar_early: got %b, expected 0", retire_o);
    end
    step();
    checks++;
    if (retire_o !== 1'b1 || stageData(3) !== 32'hCAFE) begin
      failures++;
      $display("[TB] FAIL ar_retire: got %b/%h, expected 1/0000cafe", retire_o, stageData(3));
    end
    step();
    checks++;
    if (retire_count_o !== 4'd1) begin
      failures++;
      $display("[TB] FAIL ar_count: got %0d, expected 1", retire_count_o);
    end
  endtask

  // Illegal stall pattern: stage 2 held while valid stage 1 advances.
  task automatic test_checker();
    applyStimulus(1'b1, 32'hD1, '0, '0); step();
    applyStimulus(1'b0, 32'h0,  '0, '0); step();
    checks++;
    if (protocol_err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL chk_idle: got %b, expected 0", protocol_err_o);
    end
    applyStimulus(1'b0, 32'h0, 4'b0100, '0);
    step();
    checks++;
    if (protocol_err_o !== EXP_ERR) begin
      failures++;
      $display("[TB] FAIL chk_set: got %b, expected %b", protocol_err_o, EXP_ERR);
    end
    applyStimulus(1'b0, 32'h0, '0, '0);
    step();
    step();
    checks++;
    if (protocol_err_o !== EXP_ERR) begin
      failures++;
      $display("[TB] FAIL chk_sticky: got %b, expected %b", protocol_err_o, EXP_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_flow_through();
    test_bubble();
    test_flush_priority();
    test_retire_wrap();
    test_async_reset();
    test_checker();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_chain
